// File: rtl/irq_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned NUM_IRQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one interrupt source, plus rising-edge detect
// on the synchronized value.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic sync_o,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= src_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Single-outstanding interrupt controller: per-channel edge/level pending,
// fixed lowest-index priority, request/claim/complete handshake with the core.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = NUM_IRQ_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] irq_mode,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               complete,
  input  logic               claim,
  input  logic [ID_W-1:0]    complete_id,
  output logic               e_inter,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  irq_state_e         state_q, state_d;
  logic               e_inter_q, e_inter_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] in_svc_q, in_svc_d;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [ID_W-1:0]    win_id;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .src_i  (irq_src[g]),
      .sync_o (sync[g]),
      .rise_c (rise[g])
    );
  end

  assign active = pend_q & irq_mask;

  // Lowest enabled-and-pending index wins.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    e_inter_d = e_inter_q;
    irq_id_d  = irq_id_q;
    in_svc_d  = in_svc_q;
    clr       = '0;
    case (state_q)
      ST_IDLE: begin
        if (|active) begin
          state_d   = ST_REQ;
          e_inter_d = 1'b1;
          irq_id_d  = win_id;
        end
      end
      ST_REQ: begin
        if (claim) begin
          state_d            = ST_SERVICE;
          e_inter_d          = 1'b0;
          clr[irq_id_q]      = 1'b1;
          in_svc_d[irq_id_q] = 1'b1;
        end else if (!active[irq_id_q]) begin
          state_d   = ST_IDLE;
          e_inter_d = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (complete && (complete_id == irq_id_q)) begin
          state_d  = ST_IDLE;
          in_svc_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        e_inter_d = 1'b0;
      end
    endcase
  end

  // Edge pending: a new edge beats a same-cycle claim clear.
  // Level pending: follows the source but is suppressed while in service.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_mode[i]) pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
      else             pend_d[i] = sync[i] & ~in_svc_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      e_inter_q <= 1'b0;
      irq_id_q  <= '0;
      pend_q    <= '0;
      in_svc_q  <= '0;
    end else begin
      state_q   <= state_d;
      e_inter_q <= e_inter_d;
      irq_id_q  <= irq_id_d;
      pend_q    <= pend_d;
      in_svc_q  <= in_svc_d;
    end
  end

  assign e_inter = e_inter_q;
  assign irq_id  = irq_id_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NUM_IRQ=4): expected IDs are queued when
// a source is driven and popped when the controller raises its request.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_src = '0;
  logic [3:0] irq_mode = 4'b1110;
  logic [3:0] irq_mask = 4'hF;
  logic       complete = 1'b0;
  logic       claim = 1'b0;
  logic [1:0] complete_id = '0;
  logic       e_inter;
  logic [1:0] irq_id;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  irq_controller #(.NUM_IRQ(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src     (irq_src),
    .irq_mode    (irq_mode),
    .irq_mask    (irq_mask),
    .complete    (complete),
    .claim       (claim),
    .complete_id (complete_id),
    .e_inter     (e_inter),
    .irq_id      (irq_id),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for e_inter, then checks latency and the queued ID.
  task automatic wait_req(input string tag, input int exp_lat);
    int n;
    int exp_id;
    n = 0;
    exp_id = -1;
    if (exp_q.size() > 0) exp_id = exp_q.pop_front();
    while (e_inter !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(e_inter), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
  endtask

  task automatic do_claim();
    claim = 1'b1;
    tick();
    claim = 1'b0;
  endtask

  task automatic do_complete(input logic [1:0] id);
    complete    = 1'b1;
    complete_id = id;
    tick();
    complete    = 1'b0;
    complete_id = '0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_e_inter", 32'(e_inter), 32'd0);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);

    // Single edge on ch2: request, claim, complete.
    irq_src[2] = 1'b1;
    exp_q.push_back(2);
    wait_req("s1", 4);
    chk("s1_pend", 32'(pending), 32'h4);
    do_claim();
    chk("s1_claim_e", 32'(e_inter), 32'd0);
    chk("s1_claim_pend", 32'(pending), 32'h0);
    irq_src[2] = 1'b0;
    tick(2);
    do_complete(2'd2);
    tick(3);
    chk("s1_idle_e", 32'(e_inter), 32'd0);

    // Simultaneous ch1/ch3 edges: ch1 first, then ch3.
    irq_src[1] = 1'b1;
    irq_src[3] = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(3);
    wait_req("s2a", 4);
    chk("s2a_pend", 32'(pending), 32'hA);
    do_claim();
    chk("s2a_claim_pend", 32'(pending), 32'h8);
    do_complete(2'd1);
    wait_req("s2b", 1);
    do_claim();
    do_complete(2'd3);
    irq_src[1] = 1'b0;
    irq_src[3] = 1'b0;
    tick(4);
    chk("s2_idle_e", 32'(e_inter), 32'd0);

    // Level ch0 held through service re-requests; released does not.
    irq_src[0] = 1'b1;
    exp_q.push_back(0);
    wait_req("s3a", 4);
    chk("s3a_pend", 32'(pending), 32'h1);
    do_claim();
    chk("s3a_claim_pend", 32'(pending), 32'h0);
    tick(2);
    do_complete(2'd0);
    exp_q.push_back(0);
    wait_req("s3b", 1);
    do_claim();
    irq_src[0] = 1'b0;
    tick(3);
    do_complete(2'd0);
    tick(4);
    chk("s3c_e", 32'(e_inter), 32'd0);
    chk("s3c_pend", 32'(pending), 32'h0);

    // Masked ch2 accumulates pending, requests on unmask.
    irq_mask = 4'b1011;
    irq_src[2] = 1'b1;
    tick(6);
    chk("s4_masked_e", 32'(e_inter), 32'd0);
    chk("s4_masked_pend", 32'(pending), 32'h4);
    irq_mask = 4'hF;
    exp_q.push_back(2);
    wait_req("s4", 1);
    do_claim();
    chk("s4_claim_pend", 32'(pending), 32'h0);

    // Mismatched complete ignored; second ch2 edge during service.
    do_complete(2'd1);
    irq_src[2] = 1'b0;
    tick(3);
    irq_src[2] = 1'b1;
    tick(4);
    chk("s5_svc_e", 32'(e_inter), 32'd0);
    chk("s5_svc_pend", 32'(pending), 32'h4);
    do_complete(2'd2);
    exp_q.push_back(2);
    wait_req("s5", 1);
    do_claim();
    do_complete(2'd2);
    irq_src[2] = 1'b0;
    tick(4);

    // Mask drop while requesting withdraws the request.
    irq_src[1] = 1'b1;
    exp_q.push_back(1);
    wait_req("s6a", 4);
    irq_mask = 4'b1101;
    tick();
    chk("s6_drop_e", 32'(e_inter), 32'd0);
    chk("s6_drop_pend", 32'(pending), 32'h2);
    irq_mask = 4'hF;
    exp_q.push_back(1);
    wait_req("s6b", 1);
    do_claim();
    do_complete(2'd1);
    irq_src[1] = 1'b0;
    tick(4);

    // Reset during service abandons the transaction.
    irq_src[3] = 1'b1;
    exp_q.push_back(3);
    wait_req("s7a", 4);
    do_claim();
    irq_src[3] = 1'b0;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s7_rst_e", 32'(e_inter), 32'd0);
    chk("s7_rst_pend", 32'(pending), 32'h0);
    chk("s7_rst_id", 32'(irq_id), 32'd0);
    tick(3);
    irq_src[3] = 1'b1;
    exp_q.push_back(3);
    wait_req("s7b", 4);
    do_claim();
    chk("s7b_claim_e", 32'(e_inter), 32'd0);
    do_complete(2'd3);
    tick(3);
    chk("s7_idle_e", 32'(e_inter), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of interrupt source channels; legal range 2..32.
REQ-002 Parameter ID_W, default $clog2(NUM_IRQ): width of the interrupt ID.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port irq_src, input, NUM_IRQ: raw asynchronous interrupt sources.
REQ-006 Port irq_mode, input, NUM_IRQ: per-channel mode; 1 = rising-edge, 0 = level.
REQ-007 Port irq_mask, input, NUM_IRQ: per-channel enable; 1 = enabled.
REQ-008 Port complete, input, 1: one-cycle pulse from the core marking end of service.
REQ-009 Port claim, input, 1: one-cycle pulse from the core accepting the current request.
REQ-010 Port complete_id, input, ID_W: ID being completed; qualified by complete.
REQ-011 Port e_inter, output, 1: registered interrupt request to the core.
REQ-012 Port irq_id, output, ID_W: registered ID of the requested or in-service channel.
REQ-013 Port pending, output, NUM_IRQ: registered per-channel pending bits.

Function
REQ-014 Each irq_src bit SHALL pass a two-flop synchronizer; all logic uses the synchronized value only.
REQ-015 Edge channel: pending SHALL set on a synchronized 0->1 transition and hold until claimed.
REQ-016 Level channel: pending SHALL equal the synchronized level, except it is forced 0 while that channel is in service.
REQ-017 Arbitration: among pending & irq_mask, the lowest index wins.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE->REQ when any enabled channel is pending; irq_id latches the winner; e_inter=1 from the next edge.
REQ-020 In REQ, irq_id SHALL stay frozen; a higher-priority channel arriving later does not pre-empt it.
REQ-021 REQ->IDLE with e_inter=0 when the latched channel is no longer enabled-and-pending (mask drop or level release), without claim.
REQ-022 REQ->SERVICE on claim: e_inter=0 next edge; the latched channel's edge pending bit clears; in-service flag set.
REQ-023 SERVICE->IDLE only on complete with complete_id==irq_id; a mismatched complete SHALL be ignored.
REQ-024 claim outside REQ and complete outside SERVICE SHALL be ignored; nesting is not supported.
REQ-025 Same-cycle edge-set and claim-clear on one channel: the set wins; pending stays 1.
REQ-026 Latency: irq_src rises before edge k, synchronized by edge k+1, pending at edge k+2, REQ/e_inter=1 at edge k+3.
REQ-027 Masked channels SHALL still accumulate pending; unmasking while pending requests on the next IDLE evaluation.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE; e_inter=0, irq_id=0, pending=0; synchronizers, edge history and in-service flags cleared.
REQ-029 rst asserted mid-REQ or mid-SERVICE SHALL abandon the transaction; no claim or complete is needed afterwards.

Structure
REQ-030 Package irq_ctrl_pkg SHALL hold the FSM state enum and the NUM_IRQ default constant.
REQ-031 Sub-module irq_sync_edge (synchronizer plus rising-edge detect, one channel) SHALL be instantiated NUM_IRQ times via generate.

Verification (NUM_IRQ=4)
REQ-032 Edge on ch2, all enabled -> e_inter=1 with irq_id=2 at edge k+3; claim -> e_inter=0 and pending[2]=0; complete_id=2 -> returns to IDLE.
REQ-033 ch1 and ch3 edges in the same cycle -> irq_id=1 first; after complete(1), irq_id=3 is requested.
REQ-034 Level ch0 held high through claim and complete(0) -> re-requests irq_id=0 right after returning to IDLE; with ch0 low at completion -> no re-request.
REQ-035 ch2 pending with irq_mask=4'b1011 -> e_inter stays 0 and pending[2]=1; unmask ch2 -> request irq_id=2.
REQ-036 complete_id=1 while servicing irq_id=2 -> stays in SERVICE; a second ch2 edge during service -> pending[2]=1, requested after complete(2).
REQ-037 rst pulsed during SERVICE -> next cycle e_inter=0, pending=0, irq_id=0; a fresh ch3 edge is served normally.
